// File: rtl/solar_wb_regs_if.sv
// Wishbone classic slave-side bundle for the solar monitor register block.
interface solar_wb_regs_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/solar_wb_regs.sv
// Wishbone register window (CTRL/STATUS/DATA/THRESH) with a 12-bit sample FIFO.
// Threshold interrupt logic is present only when SOLAR_WB_IRQ_EN is defined.
module solar_wb_regs #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_ni,
    solar_wb_regs_if.slave wbs,
    input  logic           smp_valid_i,
    input  logic [11:0]    smp_data_i,
    output logic           smp_ready_o,
    output logic           ctrl_en_o,
    output logic           irq_o
);

`ifdef SOLAR_WB_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    localparam int         PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_STATUS = 2'd1,
        REG_DATA   = 2'd2,
        REG_THRESH = 2'd3
    } reg_e;

    logic [11:0]      mem [FIFO_DEPTH];

    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic             en_q, en_d;
    logic             irq_en_q, irq_en_d;
    logic             clr_q, clr_d;
    logic [11:0]      thresh_q, thresh_d;
    logic             ovf_q, ovf_d;
    logic             thr_q, thr_d;
    logic             irq_q, irq_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]       count_q, count_d;

    logic        hit, acc, wr_acc, rd_acc;
    logic        full, empty, push, pop, drop;
    reg_e        reg_sel;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        unused_ok;

    assign unused_ok = &{1'b0, wbs.wbs_adr_i[1:0], wbs.wbs_dat_i[31:12], wbs.wbs_sel_i[3:2]};

    always_comb begin
        hit     = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
        // Accepting only while ack is low gives one ack per request, alternate-cycle acks on a held strobe.
        acc     = hit & ~ack_q;
        wr_acc  = acc & wbs.wbs_we_i;
        rd_acc  = acc & ~wbs.wbs_we_i;
        reg_sel = reg_e'(wbs.wbs_adr_i[3:2]);
        wdata   = wbs.wbs_dat_i;
        sel     = wbs.wbs_sel_i;

        full  = (count_q == DEPTH_C);
        empty = (count_q == 5'd0);
        pop   = rd_acc & (reg_sel == REG_DATA) & ~empty;
        // A pop frees the slot in the same cycle, so a full FIFO still accepts when popped.
        push  = smp_valid_i & en_q & (~full | pop) & ~clr_q;
        drop  = smp_valid_i & en_q & full & ~pop & ~clr_q;

        rdata = 32'd0;
        case (reg_sel)
            REG_CTRL:   rdata = {29'd0, irq_en_q, 1'b0, en_q};
            REG_STATUS: rdata = {20'd0, thr_q, ovf_q, empty, full, 3'd0, count_q};
            REG_DATA:   rdata = {20'd0, empty ? 12'd0 : mem[rd_ptr_q]};
            REG_THRESH: rdata = {20'd0, thresh_q};
            default:    rdata = 32'd0;
        endcase
    end

    always_comb begin
        ack_d    = acc;
        dat_d    = rd_acc ? rdata : 32'd0;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        clr_d    = 1'b0;
        thresh_d = thresh_q;
        ovf_d    = ovf_q;
        thr_d    = thr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_acc) begin
            case (reg_sel)
                REG_CTRL: begin
                    if (sel[0]) begin
                        en_d     = wdata[0];
                        clr_d    = wdata[1];
                        irq_en_d = IRQ_ON & wdata[2];
                    end
                end
                REG_STATUS: begin
                    if (sel[1]) begin
                        if (wdata[10]) ovf_d = 1'b0;
                        if (wdata[11]) thr_d = 1'b0;
                    end
                end
                REG_THRESH: begin
                    if (sel[0]) thresh_d[7:0]  = wdata[7:0];
                    if (sel[1]) thresh_d[11:8] = wdata[11:8];
                end
                default: ;
            endcase
        end

        // Sticky sets are applied after W1C so a same-cycle event wins.
        if (drop) ovf_d = 1'b1;
        if (IRQ_ON && push && (smp_data_i > thresh_q)) thr_d = 1'b1;

        if (clr_q) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = 5'd0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {4'd0, push} - {4'd0, pop};
        end

        irq_d = IRQ_ON & irq_en_q & (thr_q | ovf_q);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q    <= 1'b0;
            dat_q    <= 32'd0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            clr_q    <= 1'b0;
            thresh_q <= 12'hFFF;
            ovf_q    <= 1'b0;
            thr_q    <= 1'b0;
            irq_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 5'd0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            clr_q    <= clr_d;
            thresh_q <= thresh_d;
            ovf_q    <= ovf_d;
            thr_q    <= thr_d;
            irq_q    <= irq_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sample storage carries no reset; stale entries are hidden by count.
    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr_q] <= smp_data_i;
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign smp_ready_o   = ~full;
    assign ctrl_en_o     = en_q;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_solar_wb_regs.sv
// Scoreboard bench for solar_wb_regs: expected read data queued at request, checked at ack.
module tb_solar_wb_regs;
    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam int          DEPTH    = 8;
    localparam logic [31:0] A_CTRL   = BASE;
    localparam logic [31:0] A_STATUS = BASE + 32'h4;
    localparam logic [31:0] A_DATA   = BASE + 32'h8;
    localparam logic [31:0] A_THRESH = BASE + 32'hC;
`ifdef SOLAR_WB_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        smp_valid = 1'b0;
    logic [11:0] smp_data = 12'd0;
    logic        smp_ready, ctrl_en, irq;

    solar_wb_regs_if bus();

    solar_wb_regs #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs        (bus),
        .smp_valid_i(smp_valid),
        .smp_data_i (smp_data),
        .smp_ready_o(smp_ready),
        .ctrl_en_o  (ctrl_en),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [11:0] fifo_model[$];
    bit          en_model = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wb_read(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                           input bit with_push, input logic [11:0] pd);
        int          lat;
        bit          got;
        logic [31:0] obs;
        logic [31:0] e;
        @(negedge clk);
        check_val({tag, "_idle_ack"}, {31'd0, bus.wbs_ack_o}, 32'd0);
        check_val({tag, "_idle_dat"}, bus.wbs_dat_o, 32'd0);
        exp_q.push_back(exp);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = addr; bus.wbs_dat_i = 32'd0;
        if (with_push) begin smp_valid = 1'b1; smp_data = pd; end
        lat = 0; got = 1'b0; obs = 32'd0;
        while (!got && lat < 6) begin
            @(negedge clk);
            lat++;
            smp_valid = 1'b0;
            if (bus.wbs_ack_o) begin got = 1'b1; obs = bus.wbs_dat_o; end
            else check_val({tag, "_dat_zero"}, bus.wbs_dat_o, 32'd0);
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        e = exp_q.pop_front();
        check_val({tag, "_ack"}, {31'd0, got}, 32'd1);
        check_val({tag, "_lat"}, 32'(lat), 32'd1);
        check_val(tag, obs, e);
        $display("RD %-12s adr=%h dat=%h exp=%h lat=%0d", tag, addr, obs, e, lat);
    endtask

    task automatic wb_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] sel);
        int lat;
        bit got;
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
        bus.wbs_sel_i = sel; bus.wbs_adr_i = addr; bus.wbs_dat_i = data;
        lat = 0; got = 1'b0;
        while (!got && lat < 6) begin
            @(negedge clk);
            lat++;
            if (bus.wbs_ack_o) got = 1'b1;
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        check_val({tag, "_ack"}, {31'd0, got}, 32'd1);
        check_val({tag, "_lat"}, 32'(lat), 32'd1);
        $display("WR %-12s adr=%h dat=%h sel=%b lat=%0d", tag, addr, data, sel, lat);
    endtask

    task automatic push_sample(input logic [11:0] d);
        @(negedge clk);
        smp_valid = 1'b1; smp_data = d;
        if (en_model && fifo_model.size() < DEPTH) fifo_model.push_back(d);
        @(negedge clk);
        smp_valid = 1'b0;
        $display("PUSH data=%h ready=%b model_count=%0d", d, smp_ready, fifo_model.size());
    endtask

    task automatic read_data(input string tag, input bit with_push, input logic [11:0] pd);
        logic [31:0] e;
        e = (fifo_model.size() > 0) ? {20'd0, fifo_model.pop_front()} : 32'd0;
        if (with_push) fifo_model.push_back(pd);
        wb_read(tag, A_DATA, e, with_push, pd);
    endtask

    initial begin
        int acks;
        bit got;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'd0; bus.wbs_dat_i = 32'd0;

        #3;
        check_val("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        check_val("rst_dat", bus.wbs_dat_o, 32'd0);
        check_val("rst_en", {31'd0, ctrl_en}, 32'd0);
        check_val("rst_irq", {31'd0, irq}, 32'd0);
        check_val("rst_ready", {31'd0, smp_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        wb_read("status_rst", A_STATUS, 32'h0000_0200, 1'b0, 12'd0);
        wb_read("thresh_rst", A_THRESH, 32'h0000_0FFF, 1'b0, 12'd0);

        // Held strobe: acks must alternate.
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = A_CTRL;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.wbs_ack_o) acks++;
            else check_val("held_dat_zero", bus.wbs_dat_o, 32'd0);
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        check_val("held_acks", 32'(acks), 32'd2);
        $display("HELD strobe 4 cycles acks=%0d", acks);

        push_sample(12'h055);
        wb_read("status_dis", A_STATUS, 32'h0000_0200, 1'b0, 12'd0);

        wb_write("ctrl_en", A_CTRL, 32'h1, 4'hF);
        en_model = 1'b1;
        @(negedge clk);
        check_val("ctrl_en_o", {31'd0, ctrl_en}, 32'd1);

        for (int i = 1; i <= 9; i++) push_sample(12'(i));
        wb_read("status_full", A_STATUS, 32'h0000_0508, 1'b0, 12'd0);
        check_val("ready_full", {31'd0, smp_ready}, 32'd0);

        wb_write("w1c_badsel", A_STATUS, 32'h400, 4'b0001);
        wb_read("status_keep", A_STATUS, 32'h0000_0508, 1'b0, 12'd0);
        wb_write("w1c_ovf", A_STATUS, 32'h400, 4'b0010);
        wb_read("status_clr", A_STATUS, 32'h0000_0108, 1'b0, 12'd0);

        read_data("data_pp", 1'b1, 12'h0AA);
        wb_read("status_pp", A_STATUS, 32'h0000_0108, 1'b0, 12'd0);
        for (int i = 0; i < DEPTH; i++) read_data("data_drain", 1'b0, 12'd0);
        wb_read("status_empty", A_STATUS, 32'h0000_0200, 1'b0, 12'd0);
        read_data("data_empty", 1'b0, 12'd0);
        wb_read("status_empty2", A_STATUS, 32'h0000_0200, 1'b0, 12'd0);
        check_val("ready_empty", {31'd0, smp_ready}, 32'd1);

        wb_write("thr_wr", A_THRESH, 32'hFFFF_F123, 4'b0001);
        wb_read("thr_byte0", A_THRESH, 32'h0000_0F23, 1'b0, 12'd0);
        wb_write("thr_wr", A_THRESH, 32'h0000_0800, 4'hF);
        wb_read("thr_full", A_THRESH, 32'h0000_0800, 1'b0, 12'd0);

        wb_write("ctrl_5", A_CTRL, 32'h5, 4'hF);
        wb_read("ctrl_rd5", A_CTRL, IRQ_ON ? 32'h5 : 32'h1, 1'b0, 12'd0);
        push_sample(12'h801);
        check_val("irq_early", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check_val("irq_set", {31'd0, irq}, {31'd0, IRQ_ON});
        wb_read("status_thr", A_STATUS, IRQ_ON ? 32'h0000_0801 : 32'h0000_0001, 1'b0, 12'd0);
        wb_write("w1c_thr", A_STATUS, 32'h800, 4'b0010);
        @(negedge clk);
        check_val("irq_clr", {31'd0, irq}, 32'd0);
        wb_read("status_thr0", A_STATUS, 32'h0000_0001, 1'b0, 12'd0);

        wb_write("ctrl_clr", A_CTRL, 32'h0000_0103, 4'b0001);
        fifo_model.delete();
        wb_read("ctrl_rd1", A_CTRL, 32'h1, 1'b0, 12'd0);
        wb_read("status_flush", A_STATUS, 32'h0000_0200, 1'b0, 12'd0);

        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = BASE + 32'h10;
        got = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.wbs_ack_o) got = 1'b1;
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        check_val("nohit_ack", {31'd0, got}, 32'd0);
        $display("RD nohit adr=%h acked=%b", BASE + 32'h10, got);

        // Reset in the middle of a read with a non-empty FIFO.
        push_sample(12'h123);
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = A_STATUS;
        #2 rst_n = 1'b0;
        #1 check_val("midrst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        check_val("midrst_en", {31'd0, ctrl_en}, 32'd0);
        @(negedge clk);
        check_val("midrst_ack2", {31'd0, bus.wbs_ack_o}, 32'd0);
        check_val("midrst_dat", bus.wbs_dat_o, 32'd0);
        check_val("midrst_ready", {31'd0, smp_ready}, 32'd1);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fifo_model.delete();
        en_model = 1'b0;
        $display("RESET mid-transaction released");
        wb_read("status_rst2", A_STATUS, 32'h0000_0200, 1'b0, 12'd0);
        wb_read("thresh_rst2", A_THRESH, 32'h0000_0FFF, 1'b0, 12'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
